// File: rtl/relu_pkg.sv
// relu_pkg: shared constants, FSM state type and lane helper for the ReLU
// sequencer slice.
//   LANES / LANE_W / DATA_W : word geometry (4 x 16-bit two's complement lanes)
//   state_t                 : sequencer FSM states
//   lane_neg_count()        : number of lanes whose sign bit is set
package relu_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 16;
    localparam int DATA_W = LANES * LANE_W;
    localparam int CNT_W  = $clog2(LANES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] lane_neg_count(input logic [DATA_W-1:0] w);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int l = 0; l < LANES; l++) begin
            n = n + CNT_W'(w[l*LANE_W + LANE_W - 1]);
        end
        return n;
    endfunction

endpackage

// File: rtl/relu.sv
// relu: combinational 4-lane ReLU on a 64-bit word.
//   en     : 1 = zero every negative lane, 0 = pass the word untouched
//   inImg  : input word, LANES lanes of LANE_W bits
//   outImg : result word
module relu
    import relu_pkg::*;
(
    input  logic              en,
    input  logic [DATA_W-1:0] inImg,
    output logic [DATA_W-1:0] outImg
);

    always_comb begin
        outImg = inImg;
        for (int l = 0; l < LANES; l++) begin
            if (en && inImg[l*LANE_W + LANE_W - 1]) begin
                outImg[l*LANE_W +: LANE_W] = {LANE_W{1'b0}};
            end
        end
    end

endmodule

// File: rtl/relu_out_fifo.sv
// relu_out_fifo: 2-entry FIFO of {destination address, result word}.
//   push_i / push_addr_i / push_data_i : write side
//   pop_i                              : remove head (caller guarantees non-empty)
//   count_o                            : occupancy 0..2
//   head_addr_o / head_data_o          : oldest entry, stable until popped
// Storage is not reset; only pointers and occupancy are.
module relu_out_fifo #(
    parameter int AW = 10,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [AW-1:0] push_addr_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [1:0]    count_o,
    output logic [AW-1:0] head_addr_o,
    output logic [DW-1:0] head_data_o
);

    logic [AW-1:0] addr_mem [2];
    logic [DW-1:0] data_mem [2];
    logic          wp_q, wp_d;
    logic          rp_q, rp_d;
    logic [1:0]    count_q, count_d;

    always_comb begin
        wp_d    = push_i ? ~wp_q : wp_q;
        rp_d    = pop_i  ? ~rp_q : rp_q;
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_mem[wp_q] <= push_addr_i;
            data_mem[wp_q] <= push_data_i;
        end
    end

    assign count_o     = count_q;
    assign head_addr_o = addr_mem[rp_q];
    assign head_data_o = data_mem[rp_q];

endmodule

// File: rtl/relu_seq_ctrl.sv
// relu_seq_ctrl: runs a block of 64-bit words from a source buffer through the
// 4-lane ReLU and streams the results to a destination port.
//   clk, rst                 : clock, asynchronous active-high reset
//   start, relu_en, src_base,
//   dst_base, len            : pass request and config (latched at start in IDLE)
//   busy, done               : pass status; done pulses once at the end
//   rd_en, rd_addr, rd_data  : source read port, data returns one cycle later
//   wr_valid, wr_ready,
//   wr_addr, wr_data         : destination handshake, head of output FIFO
//   neg_count                : lanes clamped in the current or last pass
module relu_seq_ctrl
    import relu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              relu_en,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W+2:0] neg_count
);

    state_t            state_q, state_d;
    logic              relu_en_q;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [ADDR_W-1:0] rd_idx_q, push_idx_q;
    logic [ADDR_W:0]   rd_left_q, wr_left_q;
    logic              inflight_q;
    logic [ADDR_W+2:0] neg_q;

    logic              start_pass;
    logic              pop;
    logic              push;
    logic [1:0]        fifo_count;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] relu_out;
    logic [CNT_W-1:0]  neg_lanes;
    logic [2:0]        occ;

    assign start_pass = (state_q == IDLE) && start;
    assign wr_valid   = (fifo_count != 2'd0);
    assign pop        = wr_valid && wr_ready;
    // Word returning from the source this cycle is the one requested last cycle.
    assign push       = inflight_q;
    assign neg_lanes  = relu_en_q ? lane_neg_count(rd_data) : '0;
    assign occ        = 3'(fifo_count) + 3'(inflight_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave RUN in the cycle the last word is accepted so done follows it
    // directly; a zero-length pass leaves on its first RUN cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (wr_left_q == '0 || (pop && wr_left_q == (ADDR_W+1)'(1)))
                         state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reads are issued only while the words already queued or in flight,
    // less the one leaving this cycle, leave a free FIFO slot.
    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == FINISH);
        rd_en   = (state_q == RUN) && (rd_left_q != '0) && (occ < 3'd2 + 3'(pop));
        rd_addr = rd_en ? (src_q + rd_idx_q) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            relu_en_q  <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            rd_idx_q   <= '0;
            push_idx_q <= '0;
            rd_left_q  <= '0;
            wr_left_q  <= '0;
            inflight_q <= 1'b0;
            neg_q      <= '0;
        end else begin
            inflight_q <= rd_en;
            if (start_pass) begin
                relu_en_q  <= relu_en;
                src_q      <= src_base;
                dst_q      <= dst_base;
                rd_idx_q   <= '0;
                push_idx_q <= '0;
                rd_left_q  <= len;
                wr_left_q  <= len;
                neg_q      <= '0;
            end else begin
                if (rd_en) begin
                    rd_idx_q  <= rd_idx_q + ADDR_W'(1);
                    rd_left_q <= rd_left_q - (ADDR_W+1)'(1);
                end
                if (pop) begin
                    wr_left_q <= wr_left_q - (ADDR_W+1)'(1);
                end
                if (push) begin
                    push_idx_q <= push_idx_q + ADDR_W'(1);
                    neg_q      <= neg_q + (ADDR_W+3)'(neg_lanes);
                end
            end
        end
    end

    relu u_relu (
        .en     (relu_en_q),
        .inImg  (rd_data),
        .outImg (relu_out)
    );

    relu_out_fifo #(
        .AW (ADDR_W),
        .DW (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_addr_i (dst_q + push_idx_q),
        .push_data_i (relu_out),
        .pop_i       (pop),
        .count_o     (fifo_count),
        .head_addr_o (head_addr),
        .head_data_o (head_data)
    );

    // Masking keeps the write port at zero whenever the FIFO is empty,
    // including straight out of reset when storage is undefined.
    assign wr_addr   = wr_valid ? head_addr : '0;
    assign wr_data   = wr_valid ? head_data : '0;
    assign neg_count = neg_q;

endmodule

// File: tb/tb_relu_seq_ctrl.sv
module tb_relu_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        relu_en;
    logic [9:0]  src_base;
    logic [9:0]  dst_base;
    logic [10:0] len;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [12:0] neg_count;

    relu_seq_ctrl #(.ADDR_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .relu_en   (relu_en),
        .src_base  (src_base),
        .dst_base  (dst_base),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .neg_count (neg_count)
    );

    localparam logic [63:0] W0 = 64'h0205_63f1_0f47_005a;
    localparam logic [63:0] W1 = 64'h9205_f3f1_8f47_805a;
    localparam logic [63:0] W2 = 64'h0205_f3f1_8f47_0f47;
    localparam logic [63:0] W3 = 64'h8000_7fff_0000_ffff;
    localparam logic [63:0] R2 = 64'h0205_0000_0000_0f47;
    localparam logic [63:0] R3 = 64'h0000_7fff_0000_0000;

    typedef struct {
        logic            relu_en;
        logic [9:0]      src;
        logic [9:0]      dst;
        logic [10:0]     len;
        logic            rmode;
        int              exp_done;
        int              exp_neg;
        logic [3:0][63:0] exp_data;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [63:0] mem [0:1023];
    logic        rmode = 1'b0;
    int          ph = 0;

    logic        mon_on = 1'b0;
    logic [9:0]  rq [$];
    logic [9:0]  waq [$];
    logic [63:0] wdq [$];
    int          wv_cnt = 0;
    int          done_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [9:0]  prev_addr = '0;
    logic [63:0] prev_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Source SRAM model: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Downstream ready: always 1, or the repeating pattern 1,0,0.
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rmode) begin
                wr_ready = (ph == 0);
                ph = (ph == 2) ? 0 : ph + 1;
            end else begin
                wr_ready = 1'b1;
                ph = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (rd_en) rq.push_back(rd_addr);
            if (wr_valid) wv_cnt++;
            if (wr_valid && wr_ready) begin
                waq.push_back(wr_addr);
                wdq.push_back(wr_data);
            end
            if (done) done_cnt++;
            if (prev_stall) begin
                chk("stall_valid", {63'd0, wr_valid}, 64'd1);
                chk("stall_data", wr_data, prev_data);
                chk("stall_addr", {54'd0, wr_addr}, {54'd0, prev_addr});
            end
            prev_stall = wr_valid && !wr_ready;
            prev_addr  = wr_addr;
            prev_data  = wr_data;
        end
    end

    task automatic clear_mon();
        rq.delete();
        waq.delete();
        wdq.delete();
        wv_cnt     = 0;
        done_cnt   = 0;
        prev_stall = 1'b0;
        mon_on     = 1'b1;
    endtask

    task automatic issue_start(input logic en, input logic [9:0] s, input logic [9:0] d,
                               input logic [10:0] n);
        @(posedge clk);
        #1;
        relu_en  = en;
        src_base = s;
        dst_base = d;
        len      = n;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int k;
        int done_k;
        clear_mon();
        rmode = v.rmode;
        issue_start(v.relu_en, v.src, v.dst, v.len);
        k = 0;
        done_k = 0;
        while (k < 300 && !(done_k != 0 && k >= done_k + 2)) begin
            @(negedge clk);
            k++;
            if (done && done_k == 0) done_k = k;
        end
        rmode = 1'b0;
        chk({tag, "_done_seen"}, {63'd0, done_k != 0}, 64'd1);
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        if (v.exp_done != 0) chk({tag, "_done_cycle"}, 64'(done_k), 64'(v.exp_done));
        chk({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
        chk({tag, "_rd_cnt"}, 64'(rq.size()), 64'(v.len));
        chk({tag, "_wr_cnt"}, 64'(waq.size()), 64'(v.len));
        chk({tag, "_neg"}, 64'(neg_count), 64'(v.exp_neg));
        for (int i = 0; i < int'(v.len) && i < rq.size(); i++)
            chk($sformatf("%s_rd_addr%0d", tag, i), 64'(rq[i]), 64'(10'(v.src + 10'(i))));
        for (int i = 0; i < int'(v.len) && i < waq.size(); i++) begin
            chk($sformatf("%s_wr_addr%0d", tag, i), 64'(waq[i]), 64'(10'(v.dst + 10'(i))));
            chk($sformatf("%s_wr_data%0d", tag, i), wdq[i], v.exp_data[i]);
        end
        mon_on = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_rd_en"}, {63'd0, rd_en}, 64'd0);
        chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        chk({tag, "_wr_valid"}, {63'd0, wr_valid}, 64'd0);
        chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        chk({tag, "_wr_data"}, wr_data, 64'd0);
        chk({tag, "_neg"}, 64'(neg_count), 64'd0);
    endtask

    vec_t vecs [4];

    initial begin
        int k;
        vecs[0] = '{1'b1, 10'h000, 10'h000, 11'd4, 1'b0, 7, 8, {R3, R2, 64'd0, W0}};
        vecs[1] = '{1'b0, 10'h000, 10'h000, 11'd4, 1'b0, 7, 0, {W3, W2, W1, W0}};
        vecs[2] = '{1'b1, 10'h000, 10'h000, 11'd3, 1'b1, 0, 6, {64'd0, R2, 64'd0, W0}};
        vecs[3] = '{1'b1, 10'h3fe, 10'h3ff, 11'd3, 1'b0, 6, 6, {64'd0, W0, 64'd0, R3}};

        for (int i = 0; i < 1024; i++) mem[i] = 64'(i) * 64'h0001_0001_0001_0001;
        mem[0] = W0;
        mem[1] = W1;
        mem[2] = W2;
        mem[3] = W3;
        mem[10'h3fe] = W3;
        mem[10'h3ff] = W1;

        rst      = 1'b1;
        start    = 1'b0;
        relu_en  = 1'b0;
        src_base = '0;
        dst_base = '0;
        len      = '0;
        rd_data  = '0;
        #3;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run_vec(vecs[0], "relu4");
        run_vec(vecs[1], "bypass4");
        run_vec(vecs[2], "stall3");
        run_vec(vecs[3], "wrap3");

        // Zero-length pass with a start pulse while busy.
        clear_mon();
        issue_start(1'b1, 10'h000, 10'h000, 11'd0);
        @(negedge clk);
        chk("len0_busy_c1", {63'd0, busy}, 64'd1);
        start = 1'b1;
        @(negedge clk);
        chk("len0_done_c2", {63'd0, done}, 64'd1);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("len0_busy_end", {63'd0, busy}, 64'd0);
        chk("len0_done_cnt", 64'(done_cnt), 64'd1);
        chk("len0_rd_cnt", 64'(rq.size()), 64'd0);
        chk("len0_wv_cnt", 64'(wv_cnt), 64'd0);
        mon_on = 1'b0;

        // Asynchronous reset in cycle 3 of a len = 8 pass.
        clear_mon();
        issue_start(1'b1, 10'h000, 10'h000, 11'd8);
        k = 0;
        repeat (3) begin
            @(negedge clk);
            k++;
        end
        chk("abort_busy_c3", {63'd0, busy}, 64'd1);
        chk("abort_wv_c3", {63'd0, wr_valid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("abort");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_idle", {63'd0, busy}, 64'd0);
        mon_on = 1'b0;

        run_vec(vecs[0], "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
